// File: rtl/multicycle_ctrl.sv
// Main control FSM for a multicycle RV32I-subset datapath: sequences fetch,
// decode, memory, ALU and writeback steps and counts retired instructions.
module multicycle_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [6:0]  op,
  input  logic        zero,
  input  logic        mem_ready,
  output logic        pcwrite,
  output logic        adrsrc,
  output logic        memwrite,
  output logic        irwrite,
  output logic [1:0]  resultsrc,
  output logic [1:0]  alusrca,
  output logic [1:0]  alusrcb,
  output logic [1:0]  aluop,
  output logic [1:0]  immsrc,
  output logic        regwrite,
  output logic        illegal_op,
  output logic [3:0]  state,
  output logic [31:0] instret
);

  localparam logic [3:0] S_FETCH    = 4'd0;
  localparam logic [3:0] S_DECODE   = 4'd1;
  localparam logic [3:0] S_MEMADR   = 4'd2;
  localparam logic [3:0] S_MEMREAD  = 4'd3;
  localparam logic [3:0] S_MEMWB    = 4'd4;
  localparam logic [3:0] S_MEMWRITE = 4'd5;
  localparam logic [3:0] S_EXECUTER = 4'd6;
  localparam logic [3:0] S_ALUWB    = 4'd7;
  localparam logic [3:0] S_EXECUTEI = 4'd8;
  localparam logic [3:0] S_JAL      = 4'd9;
  localparam logic [3:0] S_BEQ      = 4'd10;

  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;

  logic [3:0]  state_q, state_d;
  logic [31:0] instret_q, instret_d;
  logic        retire;
  logic        pcupdate, branch;
  logic        irwrite_raw, memwrite_raw, regwrite_raw, illegal_raw;

  // Next-state logic; unused encodings 11-15 fall through to FETCH.
  always_comb begin
    state_d     = S_FETCH;
    illegal_raw = 1'b0;
    case (state_q)
      S_FETCH:    state_d = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_R:         state_d = S_EXECUTER;
          OP_I:         state_d = S_EXECUTEI;
          OP_JAL:       state_d = S_JAL;
          OP_BEQ:       state_d = S_BEQ;
          default: begin
            state_d     = S_FETCH;
            illegal_raw = 1'b1;
          end
        endcase
      end
      S_MEMADR: begin
        if (op == OP_LW)      state_d = S_MEMREAD;
        else if (op == OP_SW) state_d = S_MEMWRITE;
        else                  state_d = S_FETCH;
      end
      S_MEMREAD:  state_d = mem_ready ? S_MEMWB : S_MEMREAD;
      S_MEMWB:    state_d = S_FETCH;
      S_MEMWRITE: state_d = mem_ready ? S_FETCH : S_MEMWRITE;
      S_EXECUTER: state_d = S_ALUWB;
      S_EXECUTEI: state_d = S_ALUWB;
      S_JAL:      state_d = S_ALUWB;
      S_ALUWB:    state_d = S_FETCH;
      S_BEQ:      state_d = S_FETCH;
      default:    state_d = S_FETCH;
    endcase
  end

  // An instruction retires on the edge that leaves its final state.
  always_comb begin
    retire = 1'b0;
    case (state_q)
      S_MEMWB, S_ALUWB, S_BEQ: retire = 1'b1;
      S_MEMWRITE:              retire = mem_ready;
      default:                 retire = 1'b0;
    endcase
    instret_d = retire ? instret_q + 32'd1 : instret_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_FETCH;
      instret_q <= 32'd0;
    end else begin
      state_q   <= state_d;
      instret_q <= instret_d;
    end
  end

  // Moore output decode; FETCH values double as the reset values since
  // reset forces the state register to FETCH asynchronously.
  always_comb begin
    adrsrc       = 1'b0;
    irwrite_raw  = 1'b0;
    memwrite_raw = 1'b0;
    regwrite_raw = 1'b0;
    resultsrc    = 2'b00;
    alusrca      = 2'b00;
    alusrcb      = 2'b00;
    aluop        = 2'b00;
    pcupdate     = 1'b0;
    branch       = 1'b0;
    case (state_q)
      S_FETCH: begin
        irwrite_raw = mem_ready;
        alusrcb     = 2'b10;
        resultsrc   = 2'b10;
        pcupdate    = mem_ready;
      end
      S_DECODE: begin
        alusrca = 2'b01;
        alusrcb = 2'b01;
      end
      S_MEMADR: begin
        alusrca = 2'b10;
        alusrcb = 2'b01;
      end
      S_MEMREAD: adrsrc = 1'b1;
      S_MEMWB: begin
        resultsrc    = 2'b01;
        regwrite_raw = 1'b1;
      end
      S_MEMWRITE: begin
        adrsrc       = 1'b1;
        memwrite_raw = 1'b1;
      end
      S_EXECUTER: begin
        alusrca = 2'b10;
        aluop   = 2'b10;
      end
      S_EXECUTEI: begin
        alusrca = 2'b10;
        alusrcb = 2'b01;
        aluop   = 2'b10;
      end
      S_ALUWB: regwrite_raw = 1'b1;
      S_JAL: begin
        alusrca  = 2'b01;
        alusrcb  = 2'b10;
        pcupdate = 1'b1;
      end
      S_BEQ: begin
        alusrca = 2'b10;
        aluop   = 2'b01;
        branch  = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    case (op)
      OP_LW, OP_I: immsrc = 2'b00;
      OP_SW:       immsrc = 2'b01;
      OP_BEQ:      immsrc = 2'b10;
      OP_JAL:      immsrc = 2'b11;
      default:     immsrc = 2'b00;
    endcase
  end

  // Strobes are gated by rst_n so they drop in the same cycle reset asserts,
  // independent of mem_ready.
  assign pcwrite    = rst_n & (pcupdate | (branch & zero));
  assign irwrite    = rst_n & irwrite_raw;
  assign memwrite   = rst_n & memwrite_raw;
  assign regwrite   = rst_n & regwrite_raw;
  assign illegal_op = rst_n & illegal_raw & (state_q == S_DECODE);
  assign state      = state_q;
  assign instret    = instret_q;

endmodule

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 SHALL have a single clock and an asynchronous, active-low reset: clk in 1, rising-edge clock; rst_n in 1, async active-low reset.
REQ-002 SHALL have these inputs: op in 7, instruction opcode [6:0]; zero in 1, ALU zero flag; mem_ready in 1, memory access complete this cycle.
REQ-003 SHALL have these outputs: pcwrite out 1, PC load enable; adrsrc out 1, memory address select (0=PC, 1=ALU result reg); memwrite out 1, memory write strobe; irwrite out 1, instruction register load.
REQ-004 SHALL have these outputs: resultsrc out 2, result mux select; alusrca out 2, ALU A select; alusrcb out 2, ALU B select; aluop out 2, class code to ALU decoder (00 add, 01 branch/sub, 10 funct-decoded).
REQ-005 SHALL have these outputs: immsrc out 2, immediate format; regwrite out 1, register file write enable; illegal_op out 1, one-cycle flag for an unsupported opcode; state out 4, current state; instret out 32, retired-instruction count.

Function
REQ-006 SHALL implement a Moore FSM with these state encodings: FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECUTER=6, ALUWB=7, EXECUTEI=8, JAL=9, BEQ=10; codes 11-15 SHALL go to FETCH on the next clock.
REQ-007 SHALL define opcodes as: lw=0000011, sw=0100011, R=0110011, I-ALU=0010011, jal=1101111, beq=1100011.
REQ-008 SHALL transition FETCH->DECODE only when mem_ready=1, and SHALL otherwise hold FETCH.
REQ-009 SHALL transition from DECODE by opcode: lw/sw->MEMADR; R->EXECUTER; I-ALU->EXECUTEI; jal->JAL; beq->BEQ; any other opcode->FETCH with illegal_op=1 for that DECODE cycle.
REQ-010 SHALL transition MEMADR->MEMREAD for lw and MEMADR->MEMWRITE for sw.
REQ-011 SHALL hold MEMREAD until mem_ready=1, then go to MEMWB; MEMWB->FETCH.
REQ-012 SHALL hold MEMWRITE until mem_ready=1, then go to FETCH.
REQ-013 SHALL sequence EXECUTER->ALUWB, EXECUTEI->ALUWB, JAL->ALUWB, ALUWB->FETCH and BEQ->FETCH.
REQ-014 SHALL drive every output not listed for a state to 0; listed values per state (2-bit fields binary) SHALL be:
- FETCH: adrsrc=0, irwrite=mem_ready, alusrca=00, alusrcb=10, aluop=00, resultsrc=10, pcupdate=mem_ready.
- DECODE: alusrca=01, alusrcb=01, aluop=00.
- MEMADR: alusrca=10, alusrcb=01, aluop=00.
- MEMREAD: adrsrc=1, resultsrc=00.
- MEMWB: resultsrc=01, regwrite=1.
- MEMWRITE: adrsrc=1, memwrite=1, held until mem_ready=1.
- EXECUTER: alusrca=10, alusrcb=00, aluop=10.
- EXECUTEI: alusrca=10, alusrcb=01, aluop=10.
- ALUWB: resultsrc=00, regwrite=1.
- JAL: alusrca=01, alusrcb=10, aluop=00, resultsrc=00, pcupdate=1.
- BEQ: alusrca=10, alusrcb=00, aluop=01, resultsrc=00, branch=1.
REQ-015 SHALL compute pcwrite = pcupdate OR (branch AND zero), combinationally within the cycle.
REQ-016 SHALL decode immsrc combinationally from op in all states: lw/I-ALU=00, sw=01, beq=10, jal=11, others=00.
REQ-017 SHALL increment instret by 1 (mod 2^32, wrapping to 0) on each clock edge that leaves MEMWB, MEMWRITE (with mem_ready=1), ALUWB or BEQ; illegal opcodes SHALL NOT count.
REQ-018 SHALL NOT time out while waiting on mem_ready.
REQ-019 SHALL drive state output equal to the state register value.

Reset
REQ-020 SHALL, while rst_n=0, force state=FETCH and instret=0 immediately (asynchronous).
REQ-021 SHALL, while rst_n=0, force pcwrite, irwrite, memwrite, regwrite and illegal_op to 0, with the mux selects taking FETCH values.
REQ-022 SHALL, on reset assertion mid-instruction (including a MEMWRITE wait), abandon the instruction, not count it, and deassert memwrite in the same cycle.
REQ-023 SHALL sample the first FETCH at the first rising clk edge after rst_n rises.

Verification
REQ-024 SHALL verify R-type: mem_ready=1, op=0110011 -> states 0,1,6,7,0; aluop=10 in EXECUTER; regwrite=1 only in ALUWB; instret 0->1.
REQ-025 SHALL verify lw with a 3-cycle stall: op=0000011, mem_ready=0 for 3 cycles in MEMREAD -> MEMREAD held 4 cycles, adrsrc=1 throughout, then MEMWB with resultsrc=01 and regwrite=1.
REQ-026 SHALL verify beq both ways: op=1100011 with zero=1 -> pcwrite=1 in BEQ, aluop=01; with zero=0 -> pcwrite=0; both return to FETCH and increment instret.
REQ-027 SHALL verify an illegal opcode: op=1111111 -> illegal_op=1 for exactly the DECODE cycle, next state FETCH, instret unchanged.
REQ-028 SHALL verify sw with a mid-operation reset: op=0100011, rst_n dropped while in MEMWRITE with mem_ready=0 -> memwrite=0 and state=0 immediately, instret=0.
REQ-029 SHALL verify instret wrap: force instret=FFFFFFFF, complete a jal (states 0,1,9,7,0, pcwrite=1 in JAL) -> instret=00000000.
